sp_ram_arbiter: RTL and testbench
=================================

# sp_ram_arbiter

Round-robin arbiter that shares one `single_port_ram` instance between `NUM_REQ` requesters. It sits directly in front of the RAM's `data`/`addr`/`we` inputs and multiplexes one transfer per clock. Each transfer uses a valid/ready handshake. Read data is routed back to the issuing requester one cycle later. A per-requester lock input allows short atomic bursts of up to `MAX_BURST` consecutive grants.

## Interface
- `DATA_WIDTH`, 16, RAM word width
- `ADDR_WIDTH`, 5, RAM address width
- `NUM_REQ`, 2, number of requesters (2..8)
- `MAX_BURST`, 4, maximum consecutive cycles one requester may hold a lock (≥2)

Ports:
- `clk` in 1: single clock; everything is sampled on its posedge
- `rst_n` in 1: reset, synchronous, active-low
- `req_valid` in NUM_REQ: request pending, one bit per requester
- `req_we` in NUM_REQ: 1 = write, 0 = read
- `req_lock` in NUM_REQ: request to keep the grant on the next cycle
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_data` in NUM_REQ*DATA_WIDTH: packed write data, same packing
- `req_ready` out NUM_REQ: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`
- `rsp_valid` out NUM_REQ: one-hot read-data-valid
- `rsp_data` out DATA_WIDTH: read data, shared by all requesters
- `ram_data` out DATA_WIDTH: to RAM `data`
- `ram_addr` out ADDR_WIDTH: to RAM `addr`
- `ram_we` out 1: to RAM `we`
- `ram_q` in DATA_WIDTH: from RAM `q`

## Operation
- **State**
  - Round-robin pointer `ptr` (0..NUM_REQ-1).
  - FSM {IDLE, LOCKED}.
  - Lock owner `own`.
  - Burst counter `cnt`, $clog2(MAX_BURST) bits.
  - Response select register `rsp_sel` (NUM_REQ bits, one-hot or zero).
- **Grant (combinational)**
  - In IDLE: grant the first requester with `req_valid` set, searching `ptr`, `ptr+1`, … with wrap modulo NUM_REQ.
  - In LOCKED: grant only `own`, and only if `req_valid[own]`. Other requesters get no grant, even when the owner is idle.
  - `req_ready` is never asserted without the matching `req_valid`, and at most one bit is set.
- **RAM drive**
  - `ram_addr` and `ram_data` follow the granted requester's fields.
  - `ram_we = |grant & req_we[g]`.
  - With no grant, `ram_we` = 0; `ram_addr` and `ram_data` are don't-care but must hold their previous value (no toggle).
- **IDLE transitions (on a transfer by g)**
  - `req_lock[g]` = 1: go to LOCKED, `own` ← g, `cnt` ← 1, `ptr` unchanged.
  - Otherwise: `ptr` ← (g+1) mod NUM_REQ.
- **LOCKED transitions (every cycle, transfer or not)**
  - Exit to IDLE with `ptr` ← (own+1) mod NUM_REQ when either:
    - `cnt` = MAX_BURST-1, or
    - `req_lock[own]` = 0 in a cycle where the owner transfers.
  - Otherwise `cnt` ← `cnt`+1. Idle owner cycles also consume burst budget, which bounds starvation.
  - The exit cycle's transfer is still performed.
- **Read return**
  - `rsp_sel` ← `grant & ~req_we` each cycle.
  - `rsp_valid` = `rsp_sel`; `rsp_data` = `ram_q` (pass-through).
- **Write-then-read** of the same address in consecutive cycles returns the new data; no forwarding is needed.

## Timing
- **Reset** (`rst_n` = 0 at a posedge):
  - `ptr` = 0, FSM = IDLE, `cnt` = 0, `rsp_sel` = 0.
  - While `rst_n` is low, `req_ready` = 0 and `ram_we` = 0 (grant gated by `rst_n`).
  - After reset release, `rsp_valid` = 0 until the first read transfer completes.
- Reset during LOCKED or with a read in flight drops the lock and suppresses that response. `rsp_valid` is 0 the cycle after the reset edge.
- Grant latency: 0 cycles (`req_ready` is combinational from `req_valid` and state).
- Read latency: a read transferred in cycle T produces `rsp_valid`/`rsp_data` in cycle T+1 for exactly one cycle. There is no backpressure on responses.
- Throughput: one transfer per cycle. Back-to-back reads from different requesters give back-to-back `rsp_valid` with a different one-hot bit each cycle.
- Worst-case wait for a continuously valid requester: (NUM_REQ-1)*MAX_BURST cycles.

## Test plan
- **Reset:** hold `rst_n`=0 with all `req_valid`=1 → `req_ready`=0, `ram_we`=0, `rsp_valid`=0. First grant after release goes to requester 0.
- **Fairness:** NUM_REQ=2, both requesters continuously valid with reads, no lock → grants alternate 0,1,0,1. `rsp_valid` alternates 01/10 one cycle behind.
- **Write/read:** requester 1 writes 0xBEEF to addr 5, then requester 0 reads addr 5 next cycle → cycle after the read, `rsp_valid`=01 and `rsp_data`=0xBEEF.
- **Lock burst:** MAX_BURST=4, requester 0 valid with lock held high, requester 1 valid → requester 0 granted 4 consecutive cycles, then requester 1 granted.
- **Lock with idle owner:** requester 0 locks, then drops valid → requester 1 gets no grant until 4 cycles after lock entry, then is granted.
- **Mid-lock reset:** assert `rst_n`=0 during a lock with a read in flight → next cycle `rsp_valid`=0. After release, FSM=IDLE and `ptr`=0.

Source files
------------

// File: rtl/sp_ram_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: per-requester request fields
// plus the shared read-response return path.
interface sp_ram_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters,
// with per-requester lock bursts of up to MAX_BURST consecutive cycles.
module sp_ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sp_ram_arbiter_if.slave       bus,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       own_q, own_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     rsp_sel_q, rsp_sel_d;
  logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]  ram_data_q, ram_data_d;

  logic                   gnt_any;
  logic [PTR_W-1:0]       gnt_idx;
  logic [NUM_REQ-1:0]     grant;
  logic [PTR_W-1:0]       cand;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Grant selection: owner-only while locked, rotating priority from ptr otherwise.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (rst_n) begin
      if (state_q == LOCKED) begin
        gnt_any = bus.req_valid[own_q];
        gnt_idx = own_q;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          cand = wrap_add(ptr_q, k);
          if (!gnt_any && bus.req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
          end
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = gnt_any && (gnt_idx == PTR_W'(i));
    end
  end

  // Address/data hold their last value when nobody is granted to avoid needless toggling.
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    if (gnt_any) begin
      ram_addr_d = bus.req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      ram_data_d = bus.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign ram_addr      = ram_addr_d;
  assign ram_data      = ram_data_d;
  assign ram_we        = gnt_any & bus.req_we[gnt_idx];
  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_sel_q;
  assign bus.rsp_data  = ram_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    cnt_d     = cnt_q;
    rsp_sel_d = grant & ~bus.req_we;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          if (bus.req_lock[gnt_idx]) begin
            state_d = LOCKED;
            own_d   = gnt_idx;
            cnt_d   = CNT_W'(1);
          end else begin
            ptr_d = wrap_add(gnt_idx, 1);
          end
        end
      end
      LOCKED: begin
        // Idle owner cycles still count, which bounds how long others can starve.
        if (cnt_q == CNT_LAST || (gnt_any && !bus.req_lock[own_q])) begin
          state_d = IDLE;
          ptr_d   = wrap_add(own_q, 1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      own_q     <= '0;
      cnt_q     <= '0;
      rsp_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      cnt_q     <= cnt_d;
      rsp_sel_q <= rsp_sel_d;
    end
  end

  // NOTE: datapath hold registers are deliberately not reset; their value is don't-care until the first grant.
  always_ff @(posedge clk) begin
    ram_addr_q <= ram_addr_d;
    ram_data_q <= ram_data_d;
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: scenario tasks with inline checks,
// plus a response scoreboard fed by the tasks and drained by a monitor.
module tb_sp_ram_arbiter;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic mon_en   = 1'b1;
  logic ram_init = 1'b1;

  typedef struct {
    logic [NR-1:0] who;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;
  rsp_t sb[$];

  logic [DW-1:0] mem       [2**AW];
  logic [DW-1:0] model_mem [2**AW];

  sp_ram_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sp_ram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .MAX_BURST(MB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ram_data (ram_data),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_q    (ram_q)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(i * 16'h0111 + 16'h1234);
  endfunction

  // Single-port RAM model: registered read, write-first not required.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= init_word(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_data;
    end
    ram_q <= mem[ram_addr];
  end

  // Response monitor: pops the scoreboard when an entry falls due.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          n_checks++;
          if (bus.rsp_valid !== e.who || bus.rsp_data !== e.data)
            $display("FAIL rsp cyc=%0d: got valid=%b data=%h expected valid=%b data=%h",
                     cyc, bus.rsp_valid, bus.rsp_data, e.who, e.data);
          else n_pass++;
        end else if (bus.rsp_valid !== '0) begin
          n_checks++;
          $display("FAIL rsp_unexpected cyc=%0d: got valid=%b expected 00", cyc, bus.rsp_valid);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] we, input logic [NR-1:0] lk,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_lock  = lk;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
  endtask

  task automatic expect_xfer(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (we) model_mem[a] = d;
    else sb.push_back('{who: NR'(1 << r), data: model_mem[a], due: cyc + 1});
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    drive('0, '0, '0, '0, '0, '0, '0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(2'b11, 2'b11, 2'b11, 5'd1, 5'd2, 16'h1111, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #2;
      n_checks++; if (bus.req_ready !== 2'b00) $display("FAIL reset_ready: got %b expected 00", bus.req_ready); else n_pass++;
      n_checks++; if (ram_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", ram_we); else n_pass++;
      n_checks++; if (bus.rsp_valid !== 2'b00) $display("FAIL reset_rsp: got %b expected 00", bus.rsp_valid); else n_pass++;
    end
    next_cycle();
    rst_n    = 1'b1;
    ram_init = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 5'd7, 5'd9, '0, '0);
    #2;
    n_checks++; if (bus.req_ready !== 2'b01) $display("FAIL first_grant: got %b expected 01", bus.req_ready); else n_pass++;
    n_checks++; if (ram_addr !== 5'd7) $display("FAIL first_addr: got %0d expected 7", ram_addr); else n_pass++;
    expect_xfer(0, 1'b0, 5'd7, '0);
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic [NR-1:0] exp_g;
      logic [AW-1:0] exp_a;
      if (i > 0) next_cycle();
      drive(2'b11, 2'b00, 2'b00, AW'(i), AW'(16 + i), '0, '0);
      #2;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? AW'(i) : AW'(16 + i);
      n_checks++; if (bus.req_ready !== exp_g) $display("FAIL fair_grant[%0d]: got %b expected %b", i, bus.req_ready, exp_g); else n_pass++;
      n_checks++; if (ram_addr !== exp_a) $display("FAIL fair_addr[%0d]: got %0d expected %0d", i, ram_addr, exp_a); else n_pass++;
      n_checks++; if (ram_we !== 1'b0) $display("FAIL fair_we[%0d]: got %b expected 0", i, ram_we); else n_pass++;
      expect_xfer(i % 2, 1'b0, exp_a, '0);
    end
    next_cycle();
    drive('0, '0, '0, 5'd3, 5'd4, '0, '0);
    #2;
    n_checks++; if (bus.req_ready !== 2'b00) $display("FAIL idle_ready: got %b expected 00", bus.req_ready); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL idle_we: got %b expected 0", ram_we); else n_pass++;
    n_checks++; if (ram_addr !== 5'd21) $display("FAIL idle_addr_hold: got %0d expected 21", ram_addr); else n_pass++;
  endtask

  task automatic test_write_read();
    next_cycle();
    drive(2'b10, 2'b10, 2'b00, 5'd0, 5'd5, 16'h0000, 16'hBEEF);
    #2;
    n_checks++; if (bus.req_ready !== 2'b10) $display("FAIL wr_grant: got %b expected 10", bus.req_ready); else n_pass++;
    n_checks++; if (ram_we !== 1'b1) $display("FAIL wr_we: got %b expected 1", ram_we); else n_pass++;
    n_checks++; if (ram_addr !== 5'd5 || ram_data !== 16'hBEEF) $display("FAIL wr_bus: got addr=%0d data=%h expected addr=5 data=beef", ram_addr, ram_data); else n_pass++;
    expect_xfer(1, 1'b1, 5'd5, 16'hBEEF);
    next_cycle();
    drive(2'b01, 2'b00, 2'b00, 5'd5, 5'd0, '0, '0);
    #2;
    n_checks++; if (bus.req_ready !== 2'b01) $display("FAIL rd_grant: got %b expected 01", bus.req_ready); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL rd_we: got %b expected 0", ram_we); else n_pass++;
    expect_xfer(0, 1'b0, 5'd5, '0);
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic test_lock_burst();
    logic [NR-1:0] seq [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      int who;
      if (i > 0) next_cycle();
      drive(2'b11, 2'b00, 2'b01, AW'(8 + i), 5'd20, '0, '0);
      #2;
      who = (seq[i] == 2'b01) ? 0 : 1;
      n_checks++; if (bus.req_ready !== seq[i]) $display("FAIL lock_grant[%0d]: got %b expected %b", i, bus.req_ready, seq[i]); else n_pass++;
      expect_xfer(who, 1'b0, (who == 0) ? AW'(8 + i) : 5'd20, '0);
    end
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0);
    #2;
    n_checks++; if (bus.req_ready !== 2'b00) $display("FAIL lock_end_ready: got %b expected 00", bus.req_ready); else n_pass++;
  endtask

  task automatic test_lock_idle_owner();
    do_reset();
    drive(2'b01, 2'b00, 2'b01, 5'd3, 5'd0, '0, '0);
    #2;
    n_checks++; if (bus.req_ready !== 2'b01) $display("FAIL idle_own_entry: got %b expected 01", bus.req_ready); else n_pass++;
    expect_xfer(0, 1'b0, 5'd3, '0);
    for (int i = 1; i < MB; i++) begin
      next_cycle();
      drive(2'b10, 2'b00, 2'b00, 5'd0, 5'd12, '0, '0);
      #2;
      n_checks++; if (bus.req_ready !== 2'b00) $display("FAIL idle_own_block[%0d]: got %b expected 00", i, bus.req_ready); else n_pass++;
    end
    next_cycle();
    drive(2'b10, 2'b00, 2'b00, 5'd0, 5'd12, '0, '0);
    #2;
    n_checks++; if (bus.req_ready !== 2'b10) $display("FAIL idle_own_release: got %b expected 10", bus.req_ready); else n_pass++;
    expect_xfer(1, 1'b0, 5'd12, '0);
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic test_mid_lock_reset();
    do_reset();
    drive(2'b10, 2'b00, 2'b10, 5'd0, 5'd2, '0, '0);
    #2;
    n_checks++; if (bus.req_ready !== 2'b10) $display("FAIL mlr_entry: got %b expected 10", bus.req_ready); else n_pass++;
    mon_en = 1'b0;
    next_cycle();
    drive(2'b10, 2'b00, 2'b10, 5'd0, 5'd2, '0, '0);
    #2;
    n_checks++; if (bus.req_ready !== 2'b10) $display("FAIL mlr_locked: got %b expected 10", bus.req_ready); else n_pass++;
    next_cycle();
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 5'd6, 5'd7, '0, '0);
    #2;
    n_checks++; if (bus.req_ready !== 2'b00 || ram_we !== 1'b0) $display("FAIL mlr_in_reset: got ready=%b we=%b expected 00/0", bus.req_ready, ram_we); else n_pass++;
    next_cycle();
    rst_n = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 5'd6, 5'd7, '0, '0);
    #2;
    n_checks++; if (bus.rsp_valid !== 2'b00) $display("FAIL mlr_rsp_dropped: got %b expected 00", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.req_ready !== 2'b01) $display("FAIL mlr_idle_ptr0: got %b expected 01", bus.req_ready); else n_pass++;
    expect_xfer(0, 1'b0, 5'd6, '0);
    mon_en = 1'b1;
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) model_mem[i] = init_word(i);
    drive('0, '0, '0, '0, '0, '0, '0);
    test_reset();
    test_fairness();
    test_write_read();
    test_lock_burst();
    test_lock_idle_owner();
    test_mid_lock_reset();
    next_cycle();
    next_cycle();
    n_checks++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending expected 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
